// File: rtl/rst_seq.sv
// Reset sequencer: holds NCH reset channels until the synchronized PLL lock has been
// stable for STRETCH cycles, then releases them in order STAGGER cycles apart.
module rst_seq #(
  parameter int NCH     = 4,
  parameter int STRETCH = 16,
  parameter int STAGGER = 8,
  parameter int CW      = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           pll_locked_i,
  input  logic           sw_rst_i,
  output logic [NCH-1:0] rst_o,
  output logic           ready_o,
  output logic [7:0]     lost_cnt_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {HOLD, STABLE, RELEASE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          lock_m;
  logic          lock_s;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lock_m     <= 1'b0;
      lock_s     <= 1'b0;
      state      <= HOLD;
      cnt        <= '0;
      idx        <= '0;
      rst_o      <= '1;
      ready_o    <= 1'b0;
      lost_cnt_o <= '0;
    end else begin
      lock_m <= pll_locked_i;
      lock_s <= lock_m;
      // Lock loss outranks a software request so the event is always counted.
      if (state != HOLD && !lock_s) begin
        state   <= HOLD;
        cnt     <= '0;
        idx     <= '0;
        rst_o   <= '1;
        ready_o <= 1'b0;
        if (lost_cnt_o != 8'hFF) lost_cnt_o <= lost_cnt_o + 8'd1;
      end else if (sw_rst_i) begin
        state   <= HOLD;
        cnt     <= '0;
        idx     <= '0;
        rst_o   <= '1;
        ready_o <= 1'b0;
      end else begin
        case (state)
          HOLD: begin
            if (lock_s) begin
              state <= STABLE;
              cnt   <= '0;
            end
          end
          STABLE: begin
            if (cnt == CW'(STRETCH - 1)) begin
              rst_o[0] <= 1'b0;
              cnt      <= '0;
              if (NCH == 1) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end else begin
                state <= RELEASE;
                idx   <= IW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RELEASE: begin
            if (cnt == CW'(STAGGER - 1)) begin
              rst_o[idx] <= 1'b0;
              cnt        <= '0;
              if (idx == IW'(NCH - 1)) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Randomized and directed bench for rst_seq with a queue-based scoreboard.
module tb_rst_seq;

  localparam int NCH     = 4;
  localparam int STRETCH = 16;
  localparam int STAGGER = 8;
  localparam int EW      = NCH + 9;

  logic           clk = 1'b0;
  logic           wb_rst;
  logic           pll;
  logic           sw;
  logic [NCH-1:0] rst_o;
  logic           ready_o;
  logic [7:0]     lost_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  rst_seq #(.NCH(NCH), .STRETCH(STRETCH), .STAGGER(STAGGER), .CW(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst),
    .pll_locked_i(pll),
    .sw_rst_i    (sw),
    .rst_o       (rst_o),
    .ready_o     (ready_o),
    .lost_cnt_o  (lost_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: lock seen two edges late; sequencing is "active since cycle start",
  // and channel i is out of reset once STRETCH + i*STAGGER cycles have elapsed.
  int m_s1 = 0, m_s2 = 0, m_act = 0, m_lost = 0, m_start = 0, cyc = 0;
  always @(posedge clk) begin
    int ls;
    logic [NCH-1:0] e_rst;
    logic e_rdy;
    cyc++;
    if (wb_rst) begin
      m_s1 = 0; m_s2 = 0; m_act = 0; m_lost = 0;
    end else begin
      ls = m_s2; m_s2 = m_s1; m_s1 = int'(pll);
      if (m_act != 0 && ls == 0) begin
        m_act = 0;
        if (m_lost < 255) m_lost++;
      end else if (sw) begin
        m_act = 0;
      end else if (m_act == 0 && ls != 0) begin
        m_act = 1;
        m_start = cyc;
      end
    end
    e_rdy = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      e_rst[i] = !(m_act != 0 && (cyc - m_start) >= STRETCH + i * STAGGER);
      if (e_rst[i]) e_rdy = 1'b0;
    end
    exp_q.push_back({e_rst, e_rdy, 8'(m_lost)});
  end

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({rst_o, ready_o, lost_cnt_o} !== e) begin
          bad++;
          $display("FAIL scoreboard t=%0t got rst=%b rdy=%b lost=%0d expected rst=%b rdy=%b lost=%0d",
                   $time, rst_o, ready_o, lost_cnt_o, e[EW-1:9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts edges from the next rising edge (edge 1) to rst_o[0] release and to ready.
  task automatic measure(output int r0, output int rr);
    r0 = -1;
    rr = -1;
    for (int k = 1; k <= 200 && rr < 0; k++) begin
      @(posedge clk);
      #1;
      if (r0 < 0 && !rst_o[0]) r0 = k;
      if (ready_o) rr = k;
    end
    @(negedge clk);
  endtask

  initial begin
    int r0, rr, l0, k;
    wb_rst = 1'b1; pll = 1'b0; sw = 1'b0;
    cycles(3);
    check("reset_rst", int'(rst_o), 15);
    check("reset_lost", int'(lost_cnt_o), 0);
    wb_rst = 1'b0;
    cycles(3);

    pll = 1'b1;
    measure(r0, rr);
    check("bringup_rst0_edge", r0, 19);
    check("bringup_ready_edge", rr, 43);
    cycles(5);

    l0 = int'(lost_cnt_o);
    pll = 1'b0;
    cycles(4);
    check("run_loss_lost", int'(lost_cnt_o), l0 + 1);
    check("run_loss_rst", int'(rst_o), 15);
    pll = 1'b1;
    measure(r0, rr);
    check("relock_rst0_edge", r0, 19);
    check("relock_ready_edge", rr, 43);

    pll = 1'b0;
    cycles(4);
    l0 = int'(lost_cnt_o);
    pll = 1'b1;
    cycles(9);
    pll = 1'b0;
    cycles(1);
    pll = 1'b1;
    measure(r0, rr);
    check("glitch_rst0_edge", r0, 19);
    check("glitch_lost", int'(lost_cnt_o), l0 + 1);

    pll = 1'b0;
    cycles(4);
    pll = 1'b1;
    k = 0;
    while (k < 200 && rst_o[1]) begin
      @(negedge clk);
      k++;
    end
    check("sw_wait_rst1", k < 200 ? 1 : 0, 1);
    l0 = int'(lost_cnt_o);
    sw = 1'b1;
    cycles(1);
    check("sw_rst", int'(rst_o), 15);
    check("sw_lost", int'(lost_cnt_o), l0);
    sw = 1'b0;
    measure(r0, rr);
    check("sw_rst0_edge", r0, 17);
    check("sw_ready_edge", rr, 41);

    pll = 1'b0;
    cycles(4);
    pll = 1'b1;
    cycles(29);
    wb_rst = 1'b1;
    cycles(1);
    check("wbrst_rst", int'(rst_o), 15);
    check("wbrst_ready", int'(ready_o), 0);
    check("wbrst_lost", int'(lost_cnt_o), 0);
    wb_rst = 1'b0;
    measure(r0, rr);
    check("wbrst_rst0_edge", r0, 19);

    for (int i = 0; i < 300; i++) begin
      pll = 1'b1;
      cycles(4);
      pll = 1'b0;
      cycles(4);
    end
    check("saturate_lost", int'(lost_cnt_o), 255);

    wb_rst = 1'b1;
    cycles(2);
    wb_rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) pll = ~pll;
      sw = ($urandom_range(0, 199) == 0);
      wb_rst = ($urandom_range(0, 799) == 0);
    end
    wb_rst = 1'b0; sw = 1'b0;
    cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
